// File: rtl/uart_cfg_module.sv
// Runtime-configurable UART: baud divisor, optional parity, 1/2 stop bits, RX error flags, FWFT FIFOs.
// Optional build macro UARTCFG_LOOPBACK_EN adds i_uartcfg_LOOPBACK (RX fed from o_uartcfg_TX).

module uart_cfg_fifo #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_write,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic               i_read,
    output logic [NB_DATA-1:0] o_rdata,
    output logic               o_empty,
    output logic               o_full,
    output logic [NB_ADDR:0]   o_level
);
    localparam int unsigned DEPTH = 2**NB_ADDR;

    logic [NB_DATA-1:0] r_mem [DEPTH];
    logic [NB_ADDR-1:0] r_wptr;
    logic [NB_ADDR-1:0] r_rptr;
    logic [NB_ADDR:0]   r_level;
    logic               w_do_wr;
    logic               w_do_rd;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (NB_ADDR+1)'(DEPTH));
    assign o_level = r_level;
    assign w_do_wr = i_write & ~o_full;
    assign w_do_rd = i_read & ~o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + 1'b1;
            if (w_do_rd) r_rptr <= r_rptr + 1'b1;
            if (w_do_wr && !w_do_rd)      r_level <= r_level + 1'b1;
            else if (!w_do_wr && w_do_rd) r_level <= r_level - 1'b1;
        end
    end
endmodule

module uart_cfg_module #(
    parameter int NB_UARTCFG_DATA  = 8,
    parameter int SB_UARTCFG_TICKS = 16,
    parameter int NB_UARTCFG_DIV   = 16,
    parameter int NB_UARTCFG_ADDR  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NB_UARTCFG_DIV-1:0]  i_uartcfg_DIVISOR,
    input  logic                       i_uartcfg_PARITY_EN,
    input  logic                       i_uartcfg_PARITY_ODD,
    input  logic                       i_uartcfg_STOP2,
    input  logic                       i_uartcfg_RX,
`ifdef UARTCFG_LOOPBACK_EN
    input  logic                       i_uartcfg_LOOPBACK,
`endif
    input  logic                       i_uartcfg_fiforx_READ,
    input  logic                       i_uartcfg_fifotx_WRITE,
    input  logic [NB_UARTCFG_DATA-1:0] i_uartcfg_fifotx_WRITEDATA,
    input  logic                       i_uartcfg_CLRERR,
    output logic                       o_uartcfg_TX,
    output logic [NB_UARTCFG_DATA-1:0] o_uartcfg_fiforx_READDATA,
    output logic                       o_uartcfg_fiforx_EMPTY,
    output logic                       o_uartcfg_fifotx_FULL,
    output logic [NB_UARTCFG_ADDR:0]   o_uartcfg_fiforx_LEVEL,
    output logic [NB_UARTCFG_ADDR:0]   o_uartcfg_fifotx_LEVEL,
    output logic                       o_uartcfg_PARITYERR,
    output logic                       o_uartcfg_FRAMEERR,
    output logic                       o_uartcfg_OVERRUN
);
    localparam int NB_TICK = $clog2(2*SB_UARTCFG_TICKS);
    localparam int NB_BIT  = $clog2(NB_UARTCFG_DATA);
    localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(SB_UARTCFG_TICKS-1);
    localparam logic [NB_TICK-1:0] TICK_HALF = NB_TICK'(SB_UARTCFG_TICKS/2-1);
    localparam logic [NB_TICK-1:0] TICK_LAST2 = NB_TICK'(2*SB_UARTCFG_TICKS-1);
    localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_UARTCFG_DATA-1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // Baud generator
    logic [NB_UARTCFG_DIV-1:0] r_baud_cnt;
    logic [NB_UARTCFG_DIV-1:0] w_div;
    logic                      w_tick;

    assign w_div  = (i_uartcfg_DIVISOR < NB_UARTCFG_DIV'(2)) ? NB_UARTCFG_DIV'(2) : i_uartcfg_DIVISOR;
    assign w_tick = (r_baud_cnt >= w_div - NB_UARTCFG_DIV'(1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)    r_baud_cnt <= '0;
        else if (w_tick) r_baud_cnt <= '0;
        else             r_baud_cnt <= r_baud_cnt + 1'b1;
    end

    // RX synchroniser
    logic [1:0] r_rx_sync;
    logic       w_rx_pin;
`ifdef UARTCFG_LOOPBACK_EN
    assign w_rx_pin = i_uartcfg_LOOPBACK ? o_uartcfg_TX : i_uartcfg_RX;
`else
    assign w_rx_pin = i_uartcfg_RX;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_rx_sync <= 2'b11;
        else          r_rx_sync <= {r_rx_sync[0], w_rx_pin};
    end

    // FIFOs
    logic                       w_rx_push;
    logic                       w_rxf_full;
    logic                       w_tx_pop;
    logic                       w_txf_empty;
    logic [NB_UARTCFG_DATA-1:0] w_txf_head;
    logic [NB_UARTCFG_DATA-1:0] r_rx_shift;

    uart_cfg_fifo #(.NB_DATA(NB_UARTCFG_DATA), .NB_ADDR(NB_UARTCFG_ADDR)) u_fiforx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_write (w_rx_push),
        .i_wdata (r_rx_shift),
        .i_read  (i_uartcfg_fiforx_READ),
        .o_rdata (o_uartcfg_fiforx_READDATA),
        .o_empty (o_uartcfg_fiforx_EMPTY),
        .o_full  (w_rxf_full),
        .o_level (o_uartcfg_fiforx_LEVEL)
    );

    uart_cfg_fifo #(.NB_DATA(NB_UARTCFG_DATA), .NB_ADDR(NB_UARTCFG_ADDR)) u_fifotx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_write (i_uartcfg_fifotx_WRITE),
        .i_wdata (i_uartcfg_fifotx_WRITEDATA),
        .i_read  (w_tx_pop),
        .o_rdata (w_txf_head),
        .o_empty (w_txf_empty),
        .o_full  (o_uartcfg_fifotx_FULL),
        .o_level (o_uartcfg_fifotx_LEVEL)
    );

    // RX FSM
    state_t             r_rx_state;
    logic [NB_TICK-1:0] r_rx_cnt;
    logic [NB_BIT-1:0]  r_rx_nbit;
    logic               r_rx_par;
    logic               r_rx_paren;
    logic               r_rx_odd;
    logic               w_rx_bit_end;
    logic               w_rx_done;
    logic               w_rx_stop_ok;
    logic               w_rx_par_bad;

    assign w_rx_bit_end = w_tick && (r_rx_cnt == TICK_LAST);
    assign w_rx_done    = (r_rx_state == ST_STOP) && w_rx_bit_end;
    assign w_rx_stop_ok = r_rx_sync[1];
    assign w_rx_par_bad = r_rx_paren && (r_rx_par != ((^r_rx_shift) ^ r_rx_odd));
    assign w_rx_push    = w_rx_done && w_rx_stop_ok && !w_rx_par_bad && !w_rxf_full;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_nbit  <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_paren <= 1'b0;
            r_rx_odd   <= 1'b0;
        end else begin
            case (r_rx_state)
                ST_IDLE: begin
                    r_rx_cnt <= '0;
                    if (!r_rx_sync[1]) r_rx_state <= ST_START;
                end
                ST_START: if (w_tick) begin
                    if (r_rx_cnt == TICK_HALF) begin
                        r_rx_cnt   <= '0;
                        r_rx_nbit  <= '0;
                        r_rx_state <= r_rx_sync[1] ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                ST_DATA: if (w_tick) begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync[1], r_rx_shift[NB_UARTCFG_DATA-1:1]};
                        if (r_rx_nbit == BIT_LAST) begin
                            r_rx_paren <= i_uartcfg_PARITY_EN;
                            r_rx_odd   <= i_uartcfg_PARITY_ODD;
                            r_rx_state <= i_uartcfg_PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            r_rx_nbit <= r_rx_nbit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                ST_PARITY: if (w_tick) begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_par   <= r_rx_sync[1];
                        r_rx_state <= ST_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                ST_STOP: if (w_tick) begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky errors: a new event in the clear cycle keeps the flag set
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_uartcfg_PARITYERR <= 1'b0;
            o_uartcfg_FRAMEERR  <= 1'b0;
            o_uartcfg_OVERRUN   <= 1'b0;
        end else begin
            if (w_rx_done && !w_rx_stop_ok)
                o_uartcfg_FRAMEERR <= 1'b1;
            else if (i_uartcfg_CLRERR)
                o_uartcfg_FRAMEERR <= 1'b0;
            if (w_rx_done && w_rx_stop_ok && w_rx_par_bad)
                o_uartcfg_PARITYERR <= 1'b1;
            else if (i_uartcfg_CLRERR)
                o_uartcfg_PARITYERR <= 1'b0;
            if (w_rx_done && w_rx_stop_ok && !w_rx_par_bad && w_rxf_full)
                o_uartcfg_OVERRUN <= 1'b1;
            else if (i_uartcfg_CLRERR)
                o_uartcfg_OVERRUN <= 1'b0;
        end
    end

    // TX FSM
    state_t                     r_tx_state;
    logic [NB_TICK-1:0]         r_tx_cnt;
    logic [NB_BIT-1:0]          r_tx_nbit;
    logic [NB_UARTCFG_DATA-1:0] r_tx_shift;
    logic                       r_tx_par;
    logic                       r_tx_paren;
    logic                       r_tx_stop2;
    logic                       w_tx_bit_end;

    assign w_tx_pop     = (r_tx_state == ST_IDLE) && !w_txf_empty;
    assign w_tx_bit_end = w_tick && (r_tx_cnt == TICK_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tx_state   <= ST_IDLE;
            r_tx_cnt     <= '0;
            r_tx_nbit    <= '0;
            r_tx_shift   <= '0;
            r_tx_par     <= 1'b0;
            r_tx_paren   <= 1'b0;
            r_tx_stop2   <= 1'b0;
            o_uartcfg_TX <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    o_uartcfg_TX <= 1'b1;
                    r_tx_cnt     <= '0;
                    r_tx_nbit    <= '0;
                    if (w_tx_pop) begin
                        r_tx_shift   <= w_txf_head;
                        r_tx_par     <= (^w_txf_head) ^ i_uartcfg_PARITY_ODD;
                        r_tx_paren   <= i_uartcfg_PARITY_EN;
                        r_tx_stop2   <= i_uartcfg_STOP2;
                        o_uartcfg_TX <= 1'b0;
                        r_tx_state   <= ST_START;
                    end
                end
                ST_START: if (w_tick) begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt     <= '0;
                        o_uartcfg_TX <= r_tx_shift[0];
                        r_tx_state   <= ST_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                ST_DATA: if (w_tick) begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= r_tx_shift >> 1;
                        if (r_tx_nbit == BIT_LAST) begin
                            o_uartcfg_TX <= r_tx_paren ? r_tx_par : 1'b1;
                            r_tx_state   <= r_tx_paren ? ST_PARITY : ST_STOP;
                        end else begin
                            r_tx_nbit    <= r_tx_nbit + 1'b1;
                            o_uartcfg_TX <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                ST_PARITY: if (w_tick) begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt     <= '0;
                        o_uartcfg_TX <= 1'b1;
                        r_tx_state   <= ST_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                ST_STOP: if (w_tick) begin
                    if (r_tx_cnt == (r_tx_stop2 ? TICK_LAST2 : TICK_LAST)) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cfg_module.sv
// Directed bench for uart_cfg_module at DIVISOR=4, 16 ticks/bit (64 clocks per serial bit).

module tb_uart_cfg_module;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] divisor = 16'd4;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic        rx = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  wdata = '0;
    logic        clrerr = 1'b0;
    logic        tx;
    logic [7:0]  rdata;
    logic        rx_empty;
    logic        tx_full;
    logic [4:0]  rx_level;
    logic [4:0]  tx_level;
    logic        parerr;
    logic        frameerr;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_cfg_module #(
        .NB_UARTCFG_DATA(8),
        .SB_UARTCFG_TICKS(16),
        .NB_UARTCFG_DIV(16),
        .NB_UARTCFG_ADDR(4)
    ) dut (
        .i_clk                      (clk),
        .i_reset                    (rst_n),
        .i_uartcfg_DIVISOR          (divisor),
        .i_uartcfg_PARITY_EN        (par_en),
        .i_uartcfg_PARITY_ODD       (par_odd),
        .i_uartcfg_STOP2            (stop2),
        .i_uartcfg_RX               (rx),
        .i_uartcfg_fiforx_READ      (rd),
        .i_uartcfg_fifotx_WRITE     (wr),
        .i_uartcfg_fifotx_WRITEDATA (wdata),
        .i_uartcfg_CLRERR           (clrerr),
        .o_uartcfg_TX               (tx),
        .o_uartcfg_fiforx_READDATA  (rdata),
        .o_uartcfg_fiforx_EMPTY     (rx_empty),
        .o_uartcfg_fifotx_FULL      (tx_full),
        .o_uartcfg_fiforx_LEVEL     (rx_level),
        .o_uartcfg_fifotx_LEVEL     (tx_level),
        .o_uartcfg_PARITYERR        (parerr),
        .o_uartcfg_FRAMEERR         (frameerr),
        .o_uartcfg_OVERRUN          (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits at negedges until tx equals lvl; returns elapsed clocks
    task automatic wait_tx(input string tag, input logic lvl, output int n);
        n = 0;
        while (tx !== lvl && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) check_eq(tag, 32'(tx), 32'(lvl));
    endtask

    task automatic tx_write(input logic [7:0] b);
        wr = 1'b1;
        wdata = b;
        tick(1);
        wr = 1'b0;
    endtask

    task automatic tx_frame_check(input string tag, input logic [7:0] b, input logic pe, input logic pbit);
        int n;
        wait_tx({tag, "_start_tmo"}, 1'b0, n);
        tick(30);
        check_eq({tag, "_start"}, 32'(tx), 0);
        for (int i = 0; i < 8; i++) begin
            tick(64);
            check_eq($sformatf("%s_d%0d", tag, i), 32'(tx), 32'(b[i]));
        end
        if (pe) begin
            tick(64);
            check_eq({tag, "_par"}, 32'(tx), 32'(pbit));
        end
        tick(64);
        check_eq({tag, "_stop"}, 32'(tx), 1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic pe, input logic pbit, input logic stop_ok);
        rx = 1'b0;
        tick(64);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(64);
        end
        if (pe) begin
            rx = pbit;
            tick(64);
        end
        // A bad stop bit is held only past its sample point so the line does not look like a new start
        if (stop_ok) begin
            rx = 1'b1;
            tick(64);
        end else begin
            rx = 1'b0;
            tick(44);
            rx = 1'b1;
            tick(20);
        end
        tick(64);
    endtask

    task automatic pulse_clrerr();
        clrerr = 1'b1;
        tick(1);
        clrerr = 1'b0;
    endtask

    task automatic pulse_read();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_tx"}, 32'(tx), 1);
        check_eq({tag, "_rxlvl"}, 32'(rx_level), 0);
        check_eq({tag, "_txlvl"}, 32'(tx_level), 0);
        check_eq({tag, "_empty"}, 32'(rx_empty), 1);
        check_eq({tag, "_full"}, 32'(tx_full), 0);
        check_eq({tag, "_rdata"}, 32'(rdata), 0);
        check_eq({tag, "_errs"}, 32'({parerr, frameerr, overrun}), 0);
    endtask

    initial begin
        int n;
        tick(3);
        check_reset_state("rst");
        rst_n = 1'b1;
        tick(3);

        // 0xA5, no parity, 1 stop
        tx_write(8'hA5);
        check_eq("txlvl_after_write", 32'(tx_level), 1);
        tick(1);
        check_eq("txlvl_after_pop", 32'(tx_level), 0);
        check_eq("tx_start_low", 32'(tx), 0);
        tx_frame_check("a5", 8'hA5, 1'b0, 1'b0);

        // Exact bit timing on a second 0xA5
        tick(40);
        tx_write(8'hA5);
        wait_tx("a5t_fall_tmo", 1'b0, n);
        wait_tx("a5t_b0_tmo", 1'b1, n);
        check_eq("a5_start_len", 32'(n >= 61 && n <= 64), 1);
        wait_tx("a5t_b1_tmo", 1'b0, n);
        check_eq("a5_bit0_len", 32'(n), 64);
        wait_tx("a5t_b2_tmo", 1'b1, n);
        check_eq("a5_bit1_len", 32'(n), 64);
        tick(64*8);

        // Parity: config latched at frame start, changing ODD mid-frame has no effect
        par_en = 1'b1;
        par_odd = 1'b0;
        tx_write(8'h07);
        tick(2);
        par_odd = 1'b1;
        tx_frame_check("p_even", 8'h07, 1'b1, 1'b1);
        tick(40);
        tx_write(8'h07);
        tx_frame_check("p_odd", 8'h07, 1'b1, 1'b0);
        tick(40);

        // Two stop bits between back-to-back frames
        par_en = 1'b0;
        par_odd = 1'b0;
        stop2 = 1'b1;
        tx_write(8'h55);
        tx_write(8'h81);
        wait_tx("s2_fall_tmo", 1'b0, n);
        tick(64*8 + 30);
        check_eq("s2_bit7", 32'(tx), 0);
        wait_tx("s2_rise_tmo", 1'b1, n);
        wait_tx("s2_next_tmo", 1'b0, n);
        check_eq("stop2_len", 32'(n >= 128 && n <= 130), 1);
        stop2 = 1'b0;
        tx_frame_check("s2_second", 8'h81, 1'b0, 1'b0);
        tick(200);

        // RX framing error
        rx_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_eq("ferr_set", 32'(frameerr), 1);
        check_eq("ferr_rxlvl", 32'(rx_level), 0);
        check_eq("ferr_empty", 32'(rx_empty), 1);
        pulse_clrerr();
        check_eq("ferr_clr", 32'(frameerr), 0);

        // RX parity error, then a good parity frame
        par_en = 1'b1;
        rx_frame(8'h01, 1'b1, 1'b0, 1'b1);
        check_eq("perr_set", 32'(parerr), 1);
        check_eq("perr_rxlvl", 32'(rx_level), 0);
        pulse_clrerr();
        check_eq("perr_clr", 32'(parerr), 0);
        rx_frame(8'h01, 1'b1, 1'b1, 1'b1);
        check_eq("pgood_err", 32'(parerr), 0);
        check_eq("pgood_rdata", 32'(rdata), 32'h01);
        check_eq("pgood_empty", 32'(rx_empty), 0);
        check_eq("pgood_rxlvl", 32'(rx_level), 1);
        pulse_read();
        check_eq("pgood_drained", 32'(rx_empty), 1);
        par_en = 1'b0;

        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) begin
            logic [7:0] b;
            b = 8'(i);
            rx_frame(b, 1'b0, 1'b0, 1'b1);
        end
        check_eq("ovr_rxlvl", 32'(rx_level), 16);
        check_eq("ovr_flag", 32'(overrun), 1);
        check_eq("ovr_other_errs", 32'({parerr, frameerr}), 0);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("ovr_rd%0d", i), 32'(rdata), 32'(i));
            pulse_read();
        end
        check_eq("ovr_empty", 32'(rx_empty), 1);
        check_eq("ovr_rdata0", 32'(rdata), 0);
        pulse_clrerr();
        check_eq("ovr_clr", 32'(overrun), 0);

        // Short RX glitch is rejected
        rx = 1'b0;
        tick(8);
        rx = 1'b1;
        tick(800);
        check_eq("glitch_rxlvl", 32'(rx_level), 0);
        check_eq("glitch_errs", 32'({parerr, frameerr, overrun}), 0);

        // Fill TX FIFO: 18 back-to-back writes, first is popped, last is dropped
        wr = 1'b1;
        wdata = 8'h00;
        tick(18);
        wr = 1'b0;
        check_eq("txfull_flag", 32'(tx_full), 1);
        check_eq("txfull_lvl", 32'(tx_level), 16);
        tick(200);
        check_eq("midframe_tx", 32'(tx), 0);

        // Asynchronous reset mid-frame
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check_eq("post_rst_tx", 32'(tx), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
